// File: rtl/led_pixfeed_pkg.sv
// Shared constants for the LED pixel feeder: parameter defaults, swap FSM
// encodings and the per-chain led_rgb bit order.
package led_pixfeed_pkg;

    localparam int unsigned C_LED_CHAINS_DEF       = 4;
    localparam int unsigned C_LED_CHAIN_LENGTH_DEF = 4;
    localparam int unsigned C_LED_NBANKS_DEF       = 16;
    localparam int unsigned C_LED_WIDTH_DEF        = 32;
    localparam int unsigned C_BPC_DEF              = 12;

    // Per-chain led_rgb slice is {b1,g1,r1,b0,g0,r0}; half 0 = upper, 1 = lower.
    localparam int unsigned LED_BITS_PER_CHAIN = 6;
    localparam int unsigned LED_R0 = 0;
    localparam int unsigned LED_G0 = 1;
    localparam int unsigned LED_B0 = 2;
    localparam int unsigned LED_R1 = 3;
    localparam int unsigned LED_G1 = 4;
    localparam int unsigned LED_B1 = 5;

    typedef enum logic [1:0] {
        SWAP_IDLE    = 2'd0,
        SWAP_PENDING = 2'd1,
        SWAP_ACK     = 2'd2
    } swap_state_t;

    // Address/index width that never collapses to zero bits.
    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/led_pixfeed_if.sv
// Pixel write bus into the back framebuffer.
interface led_pixfeed_if
    import led_pixfeed_pkg::*;
#(
    parameter int unsigned C_LED_CHAINS       = C_LED_CHAINS_DEF,
    parameter int unsigned C_LED_CHAIN_LENGTH = C_LED_CHAIN_LENGTH_DEF,
    parameter int unsigned C_LED_NBANKS       = C_LED_NBANKS_DEF,
    parameter int unsigned C_LED_WIDTH        = C_LED_WIDTH_DEF,
    parameter int unsigned C_BPC              = C_BPC_DEF
) ();

    localparam int unsigned CW = clog2_min1(C_LED_CHAINS);
    localparam int unsigned YW = clog2_min1(C_LED_NBANKS);
    localparam int unsigned XW = clog2_min1(C_LED_WIDTH * C_LED_CHAIN_LENGTH);
    localparam int unsigned DW = 3 * C_BPC;

    logic          wr_en;
    logic          wr_ready;
    logic [CW-1:0] wr_chain;
    logic          wr_half;
    logic [YW-1:0] wr_y;
    logic [XW-1:0] wr_x;
    logic [DW-1:0] wr_data;

    modport master (
        output wr_en, wr_chain, wr_half, wr_y, wr_x, wr_data,
        input  wr_ready
    );

    modport slave (
        input  wr_en, wr_chain, wr_half, wr_y, wr_x, wr_data,
        output wr_ready
    );

endinterface

// File: rtl/pixfeed_ram.sv
// Simple dual-port RAM: one write port, one read port with registered read.
module pixfeed_ram #(
    parameter int unsigned DW = 36,
    parameter int unsigned AW = 11
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    localparam int unsigned DEPTH = 1 << AW;

    logic [DW-1:0] mem [DEPTH];

    // Write and registered read; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/led_pixfeed.sv
// Double-buffered LED pixel feeder: streams one bit plane of the front
// buffer to the panel chains while the back buffer accepts pixel writes;
// buffers swap only on a vsync edge.
module led_pixfeed
    import led_pixfeed_pkg::*;
#(
    parameter int unsigned C_LED_CHAINS       = C_LED_CHAINS_DEF,
    parameter int unsigned C_LED_CHAIN_LENGTH = C_LED_CHAIN_LENGTH_DEF,
    parameter int unsigned C_LED_NBANKS       = C_LED_NBANKS_DEF,
    parameter int unsigned C_LED_WIDTH        = C_LED_WIDTH_DEF,
    parameter int unsigned C_BPC              = C_BPC_DEF,
    localparam int unsigned C_COLS = C_LED_WIDTH * C_LED_CHAIN_LENGTH,
    localparam int unsigned XW     = clog2_min1(C_COLS),
    localparam int unsigned YW     = clog2_min1(C_LED_NBANKS),
    localparam int unsigned BW     = clog2_min1(C_BPC),
    localparam int unsigned LW     = LED_BITS_PER_CHAIN * C_LED_CHAINS
) (
    input  logic                sys_clk,
    input  logic                sys_rst,
    input  logic [XW-1:0]       ctl_cur_x,
    input  logic [YW-1:0]       ctl_cur_y,
    input  logic [BW-1:0]       ctl_cur_bit,
    input  logic                ctl_vsync,
    output logic [LW-1:0]       led_rgb,
    led_pixfeed_if.slave        wr,
    input  logic                swap_req,
    output logic                swap_ack,
    output logic                front_sel,
    output logic [15:0]         frame_cnt
);

    localparam int unsigned CW   = clog2_min1(C_LED_CHAINS);
    localparam int unsigned AW   = YW + XW;
    localparam int unsigned DW   = 3 * C_BPC;
    localparam int unsigned NMEM = 2 * C_LED_CHAINS;

    swap_state_t state, state_next;
    logic        wr_ready_r, wr_ready_next;
    logic        swap_ack_next, front_sel_next;
    logic        vsync_q, vsync_rise;

    logic [AW-1:0] rd_addr, wr_addr;
    logic          wr_fire;
    logic [DW-1:0] rd_data [2][NMEM];

    logic [BW-1:0] bit_q;
    logic          in_range, in_range_q;
    logic          sel_q;
    logic [LW-1:0] led_next;

    assign wr.wr_ready = wr_ready_r;
    assign wr_fire     = wr.wr_en && wr_ready_r;
    assign wr_addr     = {wr.wr_y, wr.wr_x};
    assign rd_addr     = {ctl_cur_y, ctl_cur_x};
    assign in_range    = (32'(ctl_cur_x) < C_COLS) && (32'(ctl_cur_bit) < C_BPC);
    assign vsync_rise  = ctl_vsync && !vsync_q;

    // One RAM per buffer, chain and half; writes land only in the back buffer.
    for (genvar b = 0; b < 2; b++) begin : g_buf
        for (genvar m = 0; m < NMEM; m++) begin : g_mem
            logic we;
            assign we = wr_fire && (front_sel != 1'(b)) &&
                        (wr.wr_chain == CW'(m / 2)) && (wr.wr_half == 1'(m % 2));
            pixfeed_ram #(.DW(DW), .AW(AW)) u_ram (
                .clk   (sys_clk),
                .we    (we),
                .waddr (wr_addr),
                .wdata (wr.wr_data),
                .raddr (rd_addr),
                .rdata (rd_data[b][m])
            );
        end
    end

    // Bit-plane select of the front buffer's upper and lower pixel per chain.
    for (genvar c = 0; c < C_LED_CHAINS; c++) begin : g_chain
        localparam int unsigned BASE = c * LED_BITS_PER_CHAIN;
        logic [DW-1:0] up_s, lo_s;
        assign up_s = rd_data[sel_q][2*c]   >> bit_q;
        assign lo_s = rd_data[sel_q][2*c+1] >> bit_q;
        assign led_next[BASE + LED_R0] = in_range_q && up_s[0];
        assign led_next[BASE + LED_G0] = in_range_q && up_s[C_BPC];
        assign led_next[BASE + LED_B0] = in_range_q && up_s[2*C_BPC];
        assign led_next[BASE + LED_R1] = in_range_q && lo_s[0];
        assign led_next[BASE + LED_G1] = in_range_q && lo_s[C_BPC];
        assign led_next[BASE + LED_B1] = in_range_q && lo_s[2*C_BPC];
    end

    // Read pipeline: cursor qualifiers alongside the RAM read, then output bits.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            bit_q      <= '0;
            in_range_q <= 1'b0;
            sel_q      <= 1'b0;
            led_rgb    <= '0;
        end else begin
            bit_q      <= ctl_cur_bit;
            in_range_q <= in_range;
            sel_q      <= front_sel;
            led_rgb    <= led_next;
        end
    end

    // Vsync edge history and frame counter.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            vsync_q   <= 1'b0;
            frame_cnt <= '0;
        end else begin
            vsync_q <= ctl_vsync;
            if (vsync_rise) begin
                frame_cnt <= frame_cnt + 16'd1;
            end
        end
    end

    // Swap FSM state and registered outputs.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state      <= SWAP_IDLE;
            wr_ready_r <= 1'b0;
            swap_ack   <= 1'b0;
            front_sel  <= 1'b0;
        end else begin
            state      <= state_next;
            wr_ready_r <= wr_ready_next;
            swap_ack   <= swap_ack_next;
            front_sel  <= front_sel_next;
        end
    end

    // Swap FSM next state: a request waits for the next vsync edge.
    always_comb begin
        state_next     = state;
        swap_ack_next  = 1'b0;
        front_sel_next = front_sel;
        unique case (state)
            SWAP_IDLE: begin
                if (swap_req) begin
                    state_next = SWAP_PENDING;
                end
            end
            SWAP_PENDING: begin
                if (vsync_rise) begin
                    state_next = SWAP_ACK;
                end
            end
            SWAP_ACK: begin
                state_next     = SWAP_IDLE;
                swap_ack_next  = 1'b1;
                front_sel_next = !front_sel;
            end
            default: begin
                state_next = SWAP_IDLE;
            end
        endcase
        wr_ready_next = (state_next == SWAP_IDLE);
    end

endmodule
